// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per focal point, capture each channel at its programmed arrival index and sum them.
// Latency: completing frame -> out_valid after 2 clk (3 clk with BF_APOD_EN apodization weights).
// Backpressure: in_ready only in ACQ; EMIT holds out_valid/out_data until out_ready, stalling input.
module delay_sum_beamformer #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 16,
    parameter int NUM_CH = 4,
    parameter int PTS    = 1024,
    parameter int PT_W   = 10,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int SUM_W  = DATA_W + $clog2(NUM_CH),
    parameter int WGT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic [PT_W-1:0]          num_pts,
    input  logic                     cfg_we,
    input  logic [PT_W-1:0]          cfg_pt,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [IDX_W-1:0]         cfg_idx,
`ifdef BF_APOD_EN
    input  logic                     wgt_we,
    input  logic [CH_W-1:0]          wgt_ch,
    input  logic [WGT_W-1:0]         wgt_val,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IDX_W-1:0]         in_index,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [SUM_W-1:0]  out_data,
    output logic [PT_W-1:0]          out_pt,
    output logic                     miss_err
);

    // S_WGT exists only in the apodized build: it applies channel weights before the sum.
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACQ,
`ifdef BF_APOD_EN
        S_WGT,
`endif
        S_SUM,
        S_EMIT
    } state_t;

    state_t                   state, state_nxt;
    logic [PT_W-1:0]          p, p_nxt, last_pt;
    logic [NUM_CH-1:0]        mask, hit, miss, mask_nxt;
    logic [IDX_W-1:0]         tbl [PTS][NUM_CH];
    logic [IDX_W-1:0]         tgt [NUM_CH];
    logic signed [DATA_W-1:0] samp [NUM_CH];
    logic signed [SUM_W-1:0]  sum_c;
    logic                     run_q;
    logic                     fire;

    assign in_ready = (state == S_ACQ);
    assign fire     = in_valid & in_ready;

    // Point pointer wrap: num_pts of zero means the full table.
    always_comb begin
        last_pt = (num_pts == '0) ? PT_W'(PTS - 1) : num_pts - 1'b1;
        p_nxt   = (p == last_pt) ? '0 : p + 1'b1;
    end

    // Per-channel capture decision for the frame on the input this cycle.
    always_comb begin
        hit  = '0;
        miss = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!mask[c]) begin
                if (in_index == tgt[c]) begin
                    hit[c] = 1'b1;
                end else if (in_index > tgt[c]) begin
                    miss[c] = 1'b1;
                end
            end
        end
        mask_nxt = mask | hit | miss;
    end

    // Sign-extended sum of the captured (possibly weighted) samples.
    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_c = sum_c + SUM_W'(samp[c]);
        end
    end

    // Delay table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl[cfg_pt][cfg_ch] <= cfg_idx;
        end
    end

    // Row read only in FETCH so table writes to the active row wait for the next point.
    always_ff @(posedge clk) begin
        if (state == S_FETCH) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tgt[c] <= tbl[p][c];
            end
        end
    end

`ifdef BF_APOD_EN
    logic signed [WGT_W-1:0]        wgt   [NUM_CH];
    logic signed [DATA_W+WGT_W-1:0] prod  [NUM_CH];
    logic signed [DATA_W-1:0]       wsamp [NUM_CH];

    // Channel weights default to the largest positive Q1 value (near unity).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wgt[c] <= {1'b0, {(WGT_W-1){1'b1}}};
            end
        end else if (wgt_we) begin
            wgt[wgt_ch] <= wgt_val;
        end
    end

    // Q1 multiply, arithmetic shift back to sample scale, truncate.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]  = (DATA_W+WGT_W)'(samp[c]) * (DATA_W+WGT_W)'(wgt[c]);
            wsamp[c] = DATA_W'(prod[c] >>> (WGT_W - 1));
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping run aborts from any state.
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_FETCH;
                S_FETCH: state_nxt = S_ACQ;
                S_ACQ: begin
                    if (fire && (&mask_nxt)) begin
`ifdef BF_APOD_EN
                        state_nxt = S_WGT;
`else
                        state_nxt = S_SUM;
`endif
                    end
                end
`ifdef BF_APOD_EN
                S_WGT:   state_nxt = S_SUM;
`endif
                S_SUM:   state_nxt = S_EMIT;
                S_EMIT:  if (out_ready) state_nxt = S_FETCH;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Capture, sum, output hold and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_pt    <= '0;
            mask      <= '0;
            p         <= '0;
            run_q     <= 1'b0;
            miss_err  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                samp[c] <= '0;
            end
        end else begin
            run_q <= run;
            // A new run starts with a clean error flag; run rises only while idle.
            if (run && !run_q) begin
                miss_err <= 1'b0;
            end
            if (!run) begin
                out_valid <= 1'b0;
                mask      <= '0;
                p         <= '0;
            end else begin
                case (state)
                    S_ACQ: begin
                        if (fire) begin
                            mask <= mask_nxt;
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (hit[c]) begin
                                    samp[c] <= in_data[c*DATA_W +: DATA_W];
                                end else if (miss[c]) begin
                                    samp[c] <= '0;
                                end
                            end
                            if (|miss) begin
                                miss_err <= 1'b1;
                            end
                        end
                    end
`ifdef BF_APOD_EN
                    S_WGT: begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            samp[c] <= wsamp[c];
                        end
                    end
`endif
                    S_SUM: begin
                        out_data  <= sum_c;
                        out_pt    <= p;
                        out_valid <= 1'b1;
                    end
                    S_EMIT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            mask      <= '0;
                            p         <= p_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Directed bench for delay_sum_beamformer: capture/sum, stall, miss, wrap, reset recovery.
// Latency is checked against 2 clk (3 clk when BF_APOD_EN is defined).
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_delay_sum_beamformer;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 16;
    localparam int NUM_CH = 4;
    localparam int PTS    = 1024;
    localparam int PT_W   = 10;
    localparam int CH_W   = 2;
    localparam int SUM_W  = 18;
    localparam int WGT_W  = 16;
`ifdef BF_APOD_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n, run, cfg_we, in_valid, in_ready, out_valid, out_ready, miss_err;
    logic [PT_W-1:0]          num_pts, cfg_pt, out_pt;
    logic [CH_W-1:0]          cfg_ch;
    logic [IDX_W-1:0]         cfg_idx, in_index;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic signed [SUM_W-1:0]  out_data;
`ifdef BF_APOD_EN
    logic                     wgt_we;
    logic [CH_W-1:0]          wgt_ch;
    logic [WGT_W-1:0]         wgt_val;
`endif

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     n_out = 0;
    int     rise_cyc = 0;
    int     last_acc = 0;
    int     last_pt = 0;
    longint last_data = 0;
    logic   ov_q = 1'b0;
    // Per-channel gain model, Q15: 32768 is exact unity.
    longint g [NUM_CH];

    delay_sum_beamformer #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH), .PTS(PTS),
        .PT_W(PT_W), .CH_W(CH_W), .SUM_W(SUM_W), .WGT_W(WGT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .num_pts(num_pts),
        .cfg_we(cfg_we), .cfg_pt(cfg_pt), .cfg_ch(cfg_ch), .cfg_idx(cfg_idx),
`ifdef BF_APOD_EN
        .wgt_we(wgt_we), .wgt_ch(wgt_ch), .wgt_val(wgt_val),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_pt(out_pt), .miss_err(miss_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records every accepted beam sample and the first cycle of each valid.
    always @(negedge clk) begin
        if (out_valid && !ov_q) rise_cyc = cyc;
        if (out_valid && out_ready) begin
            n_out++;
            last_data = out_data;
            last_pt   = out_pt;
        end
        ov_q = out_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic longint wv(input longint x, input int c);
        return (x * g[c]) >>> 15;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] all4(input int v);
        return {4{16'(v)}};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_row(input int pt, input int t0, input int t1, input int t2, input int t3);
        int t [4];
        t = '{t0, t1, t2, t3};
        for (int ch = 0; ch < 4; ch++) begin
            cfg_we  = 1'b1;
            cfg_pt  = PT_W'(pt);
            cfg_ch  = CH_W'(ch);
            cfg_idx = IDX_W'(t[ch]);
            tick();
        end
        cfg_we = 1'b0;
    endtask

    // Present one frame and hold it until the DUT accepts it (bounded).
    task automatic send(input int idx, input logic [NUM_CH*DATA_W-1:0] dat);
        int ok;
        ok       = 0;
        in_valid = 1'b1;
        in_index = IDX_W'(idx);
        in_data  = dat;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok       = 1;
                last_acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("frame_accept", ok, 1);
    endtask

    initial begin
        int n0, acc15, ok;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef BF_APOD_EN
            g[c] = 32767;
`else
            g[c] = 32768;
`endif
        end
        rst_n = 1'b0; run = 1'b0; num_pts = '0; cfg_we = 1'b0; cfg_pt = '0;
        cfg_ch = '0; cfg_idx = '0; in_valid = 1'b0; in_index = '0; in_data = '0;
        out_ready = 1'b1;
`ifdef BF_APOD_EN
        wgt_we = 1'b0; wgt_ch = '0; wgt_val = '0;
`endif
        tick(3);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_pt", out_pt, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_miss_err", miss_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Basic capture: per-channel targets, data equals index.
        cfg_row(0, 10, 12, 12, 15);
        cfg_row(1, 1000, 1000, 1000, 1000);
        num_pts = PT_W'(2);
        run = 1'b1;
        acc15 = 0;
        for (int i = 0; i <= 20; i++) begin
            send(i, all4(i));
            if (i == 15) acc15 = last_acc;
        end
        tick(4);
        check("t1_n_out", n_out, 1);
        check("t1_data", last_data, wv(10, 0) + wv(12, 1) + wv(12, 2) + wv(15, 3));
        check("t1_pt", last_pt, 0);
        check("t1_latency", rise_cyc - acc15, LAT);
        check("t1_miss", miss_err, 0);
        @(negedge clk);
        check("t1_acq_row1", in_ready, 1);
        @(posedge clk); #1;
        run = 1'b0;
        tick(2);
        @(negedge clk);
        check("t1_idle_rdy", in_ready, 0);

        // Output stall, dropped frame during EMIT, then a missed row.
        @(posedge clk); #1;
        cfg_row(0, 5, 5, 5, 5);
        cfg_row(1, 6, 6, 6, 6);
        out_ready = 1'b0;
        n0 = n_out;
        run = 1'b1;
        send(5, all4(5));
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        check("t2_valid_seen", ok, 1);
        @(posedge clk); #1;
        in_valid = 1'b1; in_index = IDX_W'(6); in_data = all4(6);
        @(negedge clk);
        check("t2_drop6_rdy", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t2_stall_valid", out_valid, 1);
            check("t2_stall_data", out_data, 4 * wv(5, 0));
            check("t2_stall_pt", out_pt, 0);
            check("t2_stall_rdy", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_fetch_valid", out_valid, 0);
        check("t2_fetch_rdy", in_ready, 0);
        @(negedge clk);
        check("t2_acq_rdy", in_ready, 1);
        @(posedge clk); #1;
        check("t2_first_out", n_out - n0, 1);
        send(7, all4(7));
        tick(4);
        check("t2_miss_pt", last_pt, 1);
        check("t2_miss_data", last_data, 0);
        check("t2_miss_err", miss_err, 1);
        send(8, all4(8));
        tick(4);
        check("t2_wrap_pt", last_pt, 0);
        check("t2_n_out8", n_out - n0, 3);
        for (int i = 9; i <= 12; i++) send(i, all4(i));
        tick(4);
        check("t2_n_out12", n_out - n0, 7);
        check("t2_last_pt", last_pt, 0);

        // Full-scale negative sum and pointer wrap.
        run = 1'b0;
        tick(2);
        cfg_row(0, 3, 3, 3, 3);
        cfg_row(1, 4, 4, 4, 4);
        n0 = n_out;
        run = 1'b1;
        tick(2);
        check("t3_miss_cleared", miss_err, 0);
        send(3, {4{16'h8000}});
        tick(4);
        check("t3_neg_data", last_data, wv(-32768, 0) + wv(-32768, 1) + wv(-32768, 2) + wv(-32768, 3));
        check("t3_neg_pt", last_pt, 0);
        send(4, all4(1));
        tick(4);
        check("t3_pt1_data", last_data, wv(1, 0) + wv(1, 1) + wv(1, 2) + wv(1, 3));
        check("t3_pt1", last_pt, 1);
        send(5, all4(9));
        tick(4);
        check("t3_wrap_pt", last_pt, 0);
        check("t3_wrap_data", last_data, 0);
        check("t3_n_out", n_out - n0, 3);

        // Reset mid-acquisition with two channels already captured.
        run = 1'b0;
        tick(2);
        cfg_row(0, 10, 10, 20, 20);
        cfg_row(1, 25, 25, 30, 30);
        n0 = n_out;
        run = 1'b1;
        send(10, all4(10));
        send(20, all4(20));
        tick(4);
        check("t4_pre_data", last_data, wv(10, 0) + wv(10, 1) + wv(20, 2) + wv(20, 3));
        check("t4_pre_pt", last_pt, 0);
        send(25, all4(25));
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("t4_rst_valid", out_valid, 0);
        check("t4_rst_data", out_data, 0);
        check("t4_rst_pt", out_pt, 0);
        check("t4_rst_rdy", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(20, all4(20));
        tick(4);
        check("t4_post_data", last_data, wv(20, 2) + wv(20, 3));
        check("t4_post_pt", last_pt, 0);
        check("t4_post_miss", miss_err, 1);
        check("t4_n_out", n_out - n0, 2);

`ifdef BF_APOD_EN
        // Apodization: only channel 0 weighted at one half.
        run = 1'b0;
        tick(2);
        for (int c = 0; c < NUM_CH; c++) begin
            wgt_we  = 1'b1;
            wgt_ch  = CH_W'(c);
            wgt_val = (c == 0) ? 16'h4000 : 16'h0000;
            g[c]    = (c == 0) ? 16384 : 0;
            tick();
        end
        wgt_we = 1'b0;
        cfg_row(0, 40, 40, 40, 40);
        run = 1'b1;
        send(40, all4(1000));
        acc15 = last_acc;
        tick(5);
        check("t5_apod_data", last_data, 500);
        check("t5_apod_latency", rise_cyc - acc15, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
